// File: rtl/conv_ofmap_writer.sv
// Output feature-map writer: rescales/saturates accumulator words to Q8.8 and writes them raster-order to RAM.
// Optional fused ReLU when CONV_OFMAP_RELU_EN is defined.
module conv_ofmap_writer #(
    parameter int ACC_W      = 32,
    parameter int DAT_W      = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_W      = 55,
    parameter int OUT_H      = 55,
    parameter int ADDR_W     = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ACC_W-1:0]  i_acc,
    input  logic              i_acc_valid,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DAT_W-1:0]  o_mem_wdata,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [15:0]       o_drop_cnt
);

    // state  | meaning
    // IDLE   | waiting for start, valids are dropped and counted
    // RUN    | accepting pixels, one write per valid, one cycle later
    // DONE   | last pixel write + frame_done pulse, valids dropped
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DAT_W+1){1'b0}}, {(DAT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DAT_W+1){1'b1}}, {(DAT_W-1){1'b0}}};

    state_t            state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DAT_W-1:0]  wdata_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       drop_q;

    logic signed [ACC_W-1:0] shifted;
    logic [DAT_W-1:0]        sat;
    logic [DAT_W-1:0]        pix_d;
    logic                    drop_inc;

    assign shifted  = $signed(i_acc) >>> FRAC_SHIFT;
    assign drop_inc = i_acc_valid && (drop_q != 16'hFFFF);

    always_comb begin
        sat = shifted[DAT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat = {1'b0, {(DAT_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat = {1'b1, {(DAT_W-1){1'b0}}};
        end
    end

`ifdef CONV_OFMAP_RELU_EN
    assign pix_d = sat[DAT_W-1] ? '0 : sat;
`else
    assign pix_d = sat;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (drop_inc) drop_q <= drop_q + 16'd1;
                    if (i_start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= BASE;
                    end
                end
                S_RUN: begin
                    if (i_acc_valid) begin
                        we_q       <= 1'b1;
                        mem_addr_q <= addr_q;
                        wdata_q    <= pix_d;
                        addr_q     <= addr_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (row_q == LAST_ROW) begin
                                // last pixel: its write lands in the DONE cycle with frame_done
                                row_q   <= '0;
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (drop_inc) drop_q <= drop_q + 16'd1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_we     = we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_drop_cnt   = drop_q;

endmodule
